// File: rtl/irq_aggregator.sv
// irq_aggregator: sticky pending + mask + lowest-index served interrupt; IRQ_EDGE_DETECT_EN selects edge events
module irq_aggregator #(
  parameter int N_SRC = 8,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ack,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id
);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, GAP = 2'd2;
  logic [1:0] r_state;
  logic [N_SRC-1:0] r_mask, r_pending, w_evt, w_hit, w_clr;
  logic [ID_W-1:0] r_id, w_low;
  logic r_irq, w_keep;
`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] r_hist;
  always_ff @(posedge clk) r_hist <= rst ? '0 : req;
  assign w_evt = req & ~r_hist;
`else
  assign w_evt = req;
`endif
  assign w_hit = r_pending & r_mask;
  always_comb begin
    w_low = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (w_hit[i]) w_low = ID_W'(i);
  end
  assign w_keep = r_mask[r_id];
  // set events are OR-ed in after the clear so a simultaneous set wins
  assign w_clr = (r_state == ACTIVE && w_keep && ack) ? N_SRC'(1) << r_id : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_pending <= '0;
      r_irq     <= 1'b0;
      r_id      <= '0;
    end else begin
      if (mask_we) r_mask <= mask_wdata;
      r_pending <= (r_pending & ~w_clr) | w_evt;
      if (r_state == IDLE && |w_hit) begin
        r_state <= ACTIVE;
        r_irq   <= 1'b1;
        r_id    <= w_low;
      end else if (r_state == ACTIVE && (!w_keep || ack)) begin
        r_state <= w_keep ? GAP : IDLE;
        r_irq   <= 1'b0;
      end else if (r_state == GAP) r_state <= IDLE;
    end
  end
  assign mask    = r_mask;
  assign pending = r_pending;
  assign irq     = r_irq;
  assign irq_id  = r_id;
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed checks of pending/mask/FSM behaviour, level or edge build
module tb_irq_aggregator;
  logic clk = 0, rst = 0, mask_we = 0, ack = 0;
  logic [7:0] req = 0, mask_wdata = 0;
  logic [7:0] mask, pending;
  logic irq;
  logic [2:0] irq_id;
  int errors = 0, checks = 0;
  irq_aggregator #(.N_SRC(8)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .ack(ack), .mask(mask), .pending(pending), .irq(irq), .irq_id(irq_id)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; tick(); rst = 0;
  endtask
  task automatic set_mask(input logic [7:0] m);
    mask_we = 1; mask_wdata = m; tick(); mask_we = 0;
  endtask
  task automatic test_reset;
    req = 8'hFF; mask_we = 1; mask_wdata = 8'hFF; ack = 1;
    do_reset();
    req = 0; mask_we = 0; ack = 0;
    checks++; if (mask !== 8'h00) begin errors++; $display("FAIL reset_mask got %h exp 00", mask); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", irq_id); end
  endtask
  task automatic test_two_sources;
    do_reset(); set_mask(8'hFF);
    checks++; if (mask !== 8'hFF) begin errors++; $display("FAIL mask_write got %h exp ff", mask); end
    req = 8'b0010_0100; tick(); req = 0;
    checks++; if (pending !== 8'h24) begin errors++; $display("FAIL two_pending got %h exp 24", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL two_irq_early got %b exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL two_first got irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
    ack = 1; tick(); ack = 0;
    checks++; if (pending !== 8'h20) begin errors++; $display("FAIL two_ack_pending got %h exp 20", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL two_gap_irq got %b exp 0", irq); end
    ack = 1; tick(); ack = 0;
    checks++; if (irq !== 1'b0 || pending !== 8'h20) begin errors++; $display("FAIL two_idle got irq=%b pend=%h exp irq=0 pend=20", irq, pending); end
    tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("FAIL two_second got irq=%b id=%0d exp irq=1 id=5", irq, irq_id); end
    tick(2);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd5) begin errors++; $display("FAIL two_hold got irq=%b id=%0d exp irq=1 id=5", irq, irq_id); end
    ack = 1; tick(); ack = 0;
    checks++; if (pending !== 8'h00 || irq !== 1'b0) begin errors++; $display("FAIL two_done got pend=%h irq=%b exp pend=00 irq=0", pending, irq); end
  endtask
  task automatic test_masked;
    do_reset();
    req = 8'h01; tick(); req = 0;
    checks++; if (pending !== 8'h01) begin errors++; $display("FAIL masked_pending got %h exp 01", pending); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b exp 0", irq); end
    set_mask(8'h01);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL unmask_early got %b exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL unmask_irq got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
  endtask
  task automatic test_mask_drop;
    do_reset(); set_mask(8'hFF);
    req = 8'h08; tick(); req = 0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL drop_active got irq=%b id=%0d exp irq=1 id=3", irq, irq_id); end
    set_mask(8'hF7);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL drop_delay got %b exp 1", irq); end
    tick();
    checks++; if (irq !== 1'b0 || pending !== 8'h08) begin errors++; $display("FAIL drop_irq got irq=%b pend=%h exp irq=0 pend=08", irq, pending); end
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL drop_stay got %b exp 0", irq); end
  endtask
  task automatic test_held;
    do_reset(); set_mask(8'hFF);
    req = 8'h02; tick(2);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL held_active got irq=%b id=%0d exp irq=1 id=1", irq, irq_id); end
    ack = 1; tick(); ack = 0;
`ifdef IRQ_EDGE_DETECT_EN
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL held_edge got %h exp 00", pending); end
`else
    checks++; if (pending !== 8'h02) begin errors++; $display("FAIL held_level got %h exp 02", pending); end
`endif
    req = 0;
  endtask
  task automatic test_back_to_back;
    do_reset(); set_mask(8'hFF);
    req = 8'h81; tick(); req = 0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd0) begin errors++; $display("FAIL b2b_first got irq=%b id=%0d exp irq=1 id=0", irq, irq_id); end
    ack = 1; tick(); ack = 0; tick(2);
    checks++; if (irq !== 1'b1 || irq_id !== 3'd7 || pending !== 8'h80) begin errors++; $display("FAIL b2b_top got irq=%b id=%0d pend=%h exp irq=1 id=7 pend=80", irq, irq_id, pending); end
  endtask
  task automatic test_reset_active;
    do_reset(); set_mask(8'hFF);
    req = 8'h10; tick(); req = 0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("FAIL rsta_active got irq=%b id=%0d exp irq=1 id=4", irq, irq_id); end
    rst = 1; ack = 1; mask_we = 1; mask_wdata = 8'hFF; req = 8'h01; tick();
    rst = 0; ack = 0; mask_we = 0; req = 0;
    checks++; if (mask !== 8'h00 || pending !== 8'h00 || irq !== 1'b0 || irq_id !== 3'd0) begin errors++; $display("FAIL rsta_outputs got mask=%h pend=%h irq=%b id=%0d exp all 0", mask, pending, irq, irq_id); end
    set_mask(8'h04); req = 8'h04; tick(); req = 0; tick();
    checks++; if (irq !== 1'b1 || irq_id !== 3'd2) begin errors++; $display("FAIL rsta_idle got irq=%b id=%0d exp irq=1 id=2", irq, irq_id); end
  endtask
  initial begin
    test_reset();
    test_two_sources();
    test_masked();
    test_mask_drop();
    test_held();
    test_back_to_back();
    test_reset_active();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
